// File: rtl/doorlock_pkg.sv
// Shared constants, LED mode encodings and FSM state type for the door lock.
package doorlock_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    localparam logic [1:0] LED_ENT  = 2'd0;
    localparam logic [1:0] LED_OPEN = 2'd1;
    localparam logic [1:0] LED_DONE = 2'd2;
    localparam logic [1:0] LED_SET  = 2'd3;

    typedef enum logic [2:0] {
        S_ENT  = 3'd0,
        S_OPEN = 3'd1,
        S_SET  = 3'd2,
        S_DONE = 3'd3,
        S_LOCK = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter; done_o is high during the last cycle of a loaded interval,
// so a state entered together with the load lasts exactly val_i cycles.
module doorlock_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/doorlock_ctrl.sv
// Door lock sequencer: keypad digit collection, passcode compare/change,
// timed unlock window and lockout after repeated failures.
module doorlock_ctrl #(
    parameter int                    CODE_LEN     = 4,
    parameter int                    OPEN_TICKS   = 50,
    parameter int                    DONE_TICKS   = 20,
    parameter int                    MAX_FAIL     = 3,
    parameter int                    LOCK_TICKS   = 300,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = '0
) (
    input  logic       clk_10hz_i,
    input  logic       rst_i,
    input  logic       key_valid_i,
    input  logic [3:0] key_code_i,
    output logic [1:0] led_sig_o,
    output logic       unlock_o,
    output logic       alarm_o
);

    import doorlock_pkg::*;

    localparam int BW = 4 * CODE_LEN;
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(max3(OPEN_TICKS, DONE_TICKS, LOCK_TICKS) + 1);

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [BW-1:0]   code_q, code_d;
    logic [FW-1:0]   fail_inc;
    logic            is_digit, is_star, is_hash;
    logic            cnt_full, code_match;
    logic            tmr_load, tmr_done;
    logic [TW-1:0]   tmr_val;

    assign is_digit   = key_valid_i && (key_code_i <= 4'd9);
    assign is_star    = key_valid_i && (key_code_i == KEY_STAR);
    assign is_hash    = key_valid_i && (key_code_i == KEY_HASH);
    assign cnt_full   = (cnt_q == CW'(CODE_LEN));
    assign code_match = cnt_full && (buf_q == code_q);
    assign fail_inc   = fail_q + FW'(1);

    // State register
    always_ff @(posedge clk_10hz_i) begin
        if (rst_i) begin
            state_q <= S_ENT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ENT: begin
                if (is_hash) begin
                    if (code_match) begin
                        state_d = S_OPEN;
                    end else if (fail_inc == FW'(MAX_FAIL)) begin
                        state_d = S_LOCK;
                    end
                end
            end
            S_OPEN: begin
                if (is_star) begin
                    state_d = S_SET;
                end else if (tmr_done) begin
                    state_d = S_ENT;
                end
            end
            S_SET: begin
                if (is_hash && cnt_full) begin
                    state_d = S_DONE;
                end else if (is_star) begin
                    state_d = S_ENT;
                end
            end
            S_DONE, S_LOCK: begin
                if (tmr_done) begin
                    state_d = S_ENT;
                end
            end
            default: state_d = S_ENT;
        endcase
    end

    // Output decode
    always_comb begin
        led_sig_o = LED_ENT;
        unlock_o  = 1'b0;
        alarm_o   = 1'b0;
        case (state_q)
            S_OPEN:  begin led_sig_o = LED_OPEN; unlock_o = 1'b1; end
            S_SET:   led_sig_o = LED_SET;
            S_DONE:  led_sig_o = LED_DONE;
            S_LOCK:  alarm_o   = 1'b1;
            default: led_sig_o = LED_ENT;
        endcase
    end

    // Buffer, digit counter, fail counter and stored code
    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        fail_d = fail_q;
        code_d = code_q;
        if (state_d != state_q) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (state_q == S_ENT || state_q == S_SET) begin
            if (is_digit && !cnt_full) begin
                buf_d = {buf_q[BW-5:0], key_code_i};
                cnt_d = cnt_q + CW'(1);
            end else if (is_star || is_hash) begin
                // A rejected attempt starts the next one from an empty buffer
                buf_d = '0;
                cnt_d = '0;
            end
        end
        if (state_q == S_ENT && is_hash) begin
            fail_d = code_match ? '0 : fail_inc;
        end
        if (state_q == S_LOCK && state_d == S_ENT) begin
            fail_d = '0;
        end
        if (state_q == S_SET && state_d == S_DONE) begin
            code_d = buf_q;
        end
    end

    always_ff @(posedge clk_10hz_i) begin
        if (rst_i) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            fail_q <= '0;
            code_q <= DEFAULT_CODE;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            fail_q <= fail_d;
            code_q <= code_d;
        end
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_d != state_q) begin
            case (state_d)
                S_OPEN:  begin tmr_load = 1'b1; tmr_val = TW'(OPEN_TICKS); end
                S_DONE:  begin tmr_load = 1'b1; tmr_val = TW'(DONE_TICKS); end
                S_LOCK:  begin tmr_load = 1'b1; tmr_val = TW'(LOCK_TICKS); end
                default: tmr_load = 1'b0;
            endcase
        end
    end

    doorlock_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i  (clk_10hz_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed scenarios for doorlock_ctrl: open, lockout, passcode change, extra digits, races and reset.
module tb_doorlock_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       key_valid_i = 1'b0;
    logic [3:0] key_code_i = 4'h0;
    logic [1:0] led_sig_o;
    logic       unlock_o;
    logic       alarm_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    doorlock_ctrl dut (
        .clk_10hz_i  (clk),
        .rst_i       (rst_i),
        .key_valid_i (key_valid_i),
        .key_code_i  (key_code_i),
        .led_sig_o   (led_sig_o),
        .unlock_o    (unlock_o),
        .alarm_o     (alarm_o)
    );

    // Called at a negedge; the key is sampled at the next posedge, returns at the following negedge.
    task automatic press(input logic [3:0] k);
        key_valid_i = 1'b1;
        key_code_i  = k;
        @(negedge clk);
        key_valid_i = 1'b0;
        key_code_i  = 4'h0;
    endtask

    task automatic press4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic count_led(input logic [1:0] v, output int n);
        n = 0;
        while (led_sig_o === v && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({led_sig_o, unlock_o, alarm_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got led=%0d unlock=%0b alarm=%0b, want 0/0/0", led_sig_o, unlock_o, alarm_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut.fail_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_fail_cnt: got %0d want 0", dut.fail_q);
        end
    endtask

    task automatic test_open();
        int n;
        do_reset();
        press4(0, 0, 0, 0);
        press(4'hB);
        n_cmp++;
        if (led_sig_o !== 2'd1 || unlock_o !== 1'b1) begin
            n_fail++;
            $display("FAIL open_first_cycle: got led=%0d unlock=%0b want 1/1", led_sig_o, unlock_o);
        end
        count_led(2'd1, n);
        n_cmp++;
        if (n !== 50) begin
            n_fail++;
            $display("FAIL open_duration: got %0d cycles want 50", n);
        end
        n_cmp++;
        if (led_sig_o !== 2'd0 || unlock_o !== 1'b0) begin
            n_fail++;
            $display("FAIL open_expire: got led=%0d unlock=%0b want 0/0", led_sig_o, unlock_o);
        end
    endtask

    task automatic test_lockout();
        int n;
        logic saw_open;
        logic [3:0] seq [6];
        seq = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'hA};
        do_reset();
        press(0); press(0); press(4'hB);
        n_cmp++;
        if (led_sig_o !== 2'd0 || dut.fail_q !== 2'd1) begin
            n_fail++;
            $display("FAIL short_code_fail1: got led=%0d fail=%0d want 0/1", led_sig_o, dut.fail_q);
        end
        press(0); press(0); press(4'hB);
        n_cmp++;
        if (alarm_o !== 1'b0 || dut.fail_q !== 2'd2) begin
            n_fail++;
            $display("FAIL short_code_fail2: got alarm=%0b fail=%0d want 0/2", alarm_o, dut.fail_q);
        end
        press(0); press(0); press(4'hB);
        n_cmp++;
        if (alarm_o !== 1'b1 || led_sig_o !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_enter: got alarm=%0b led=%0d want 1/0", alarm_o, led_sig_o);
        end
        n = 0;
        saw_open = 1'b0;
        while (alarm_o === 1'b1 && n < 500) begin
            n++;
            if (led_sig_o !== 2'd0 || unlock_o !== 1'b0) saw_open = 1'b1;
            if (n <= 6) press(seq[n-1]);
            else @(negedge clk);
        end
        n_cmp++;
        if (n !== 300) begin
            n_fail++;
            $display("FAIL lock_duration: got %0d cycles want 300", n);
        end
        n_cmp++;
        if (saw_open !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_keys_ignored: got mode change during lockout, want none");
        end
        n_cmp++;
        if (led_sig_o !== 2'd0 || dut.fail_q !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_exit: got led=%0d fail=%0d want 0/0", led_sig_o, dut.fail_q);
        end
    endtask

    task automatic test_change();
        int n;
        do_reset();
        press4(0, 0, 0, 0); press(4'hB);
        press(4'hA);
        n_cmp++;
        if (led_sig_o !== 2'd3 || unlock_o !== 1'b0) begin
            n_fail++;
            $display("FAIL set_enter: got led=%0d unlock=%0b want 3/0", led_sig_o, unlock_o);
        end
        press4(1, 2, 3, 4); press(4'hB);
        count_led(2'd2, n);
        n_cmp++;
        if (n !== 20) begin
            n_fail++;
            $display("FAIL done_duration: got %0d cycles want 20", n);
        end
        n_cmp++;
        if (led_sig_o !== 2'd0) begin
            n_fail++;
            $display("FAIL done_expire: got led=%0d want 0", led_sig_o);
        end
        press4(1, 2, 3, 4); press(4'hB);
        n_cmp++;
        if (led_sig_o !== 2'd1) begin
            n_fail++;
            $display("FAIL new_code_opens: got led=%0d want 1", led_sig_o);
        end
        count_led(2'd1, n);
        press4(0, 0, 0, 0); press(4'hB);
        n_cmp++;
        if (led_sig_o !== 2'd0 || dut.fail_q !== 2'd1) begin
            n_fail++;
            $display("FAIL old_code_rejected: got led=%0d fail=%0d want 0/1", led_sig_o, dut.fail_q);
        end
    endtask

    task automatic test_extra_digits();
        int n;
        press4(1, 2, 3, 4); press(5); press(4'hB);
        n_cmp++;
        if (led_sig_o !== 2'd1 || dut.fail_q !== 2'd0) begin
            n_fail++;
            $display("FAIL extra_digit_opens: got led=%0d fail=%0d want 1/0", led_sig_o, dut.fail_q);
        end
        press(4'hA);
        press4(9, 9, 9, 9); press(4'hA);
        n_cmp++;
        if (led_sig_o !== 2'd0) begin
            n_fail++;
            $display("FAIL set_abort: got led=%0d want 0", led_sig_o);
        end
        press4(1, 2, 3, 4); press(4'hB);
        n_cmp++;
        if (led_sig_o !== 2'd1) begin
            n_fail++;
            $display("FAIL code_kept_after_abort: got led=%0d want 1", led_sig_o);
        end
    endtask

    task automatic test_simultaneous();
        // Still on cycle 1 of the window opened by the previous task.
        repeat (49) @(negedge clk);
        n_cmp++;
        if (unlock_o !== 1'b1) begin
            n_fail++;
            $display("FAIL open_last_cycle: got unlock=%0b want 1", unlock_o);
        end
        press(4'hA);
        n_cmp++;
        if (led_sig_o !== 2'd3) begin
            n_fail++;
            $display("FAIL star_beats_expiry: got led=%0d want 3", led_sig_o);
        end
    endtask

    task automatic test_reset_mid_set();
        int n;
        press4(5, 6, 7, 8); press(4'hB);
        count_led(2'd2, n);
        press4(5, 6, 7, 8); press(4'hB);
        press(4'hA);
        n_cmp++;
        if (led_sig_o !== 2'd3) begin
            n_fail++;
            $display("FAIL new_code_then_set: got led=%0d want 3", led_sig_o);
        end
        do_reset();
        n_cmp++;
        if ({led_sig_o, unlock_o, alarm_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_set: got led=%0d unlock=%0b alarm=%0b want 0/0/0", led_sig_o, unlock_o, alarm_o);
        end
        press4(0, 0, 0, 0); press(4'hB);
        n_cmp++;
        if (led_sig_o !== 2'd1) begin
            n_fail++;
            $display("FAIL default_code_restored: got led=%0d want 1", led_sig_o);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_open();
        test_lockout();
        test_change();
        test_extra_digits();
        test_simultaneous();
        test_reset_mid_set();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
